deltab2_gen: RTL and testbench
==============================

Name: deltab2_gen

Overview:
- Produces the output-layer bias deltas consumed by the bias2 register bank.
- Accepts a serial stream of per-neuron output errors, 5 beats per sample: neuron 1..5 in order.
- Scales each error by the learning rate and negates it, then accumulates over BATCH samples.
- Presents the five saturated deltas with a one-cycle ctrl=4'b0001 update strobe and a nonzero step count.

Parameters:
- BATCH, 1, samples accumulated per bias update (1..255).
- FRAC, 8, fractional bits of the Q-format shared by err_data, lr and the deltas.
- ACC_W, 24, accumulator width per neuron (must be >= 17).

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst  input  1  synchronous active-high reset.
- lr  input  16  signed learning rate, Q(16-FRAC).FRAC; sampled on every accepted beat.
- err_valid  input  1  error beat valid.
- err_ready  output  1  block can accept a beat.
- err_data  input  16  signed output error for the current neuron.
- deltab2_1..deltab2_5  output  16 each  signed bias deltas for neurons 1..5; registered.
- ctrl  output  4  4'b0001 for exactly one cycle per update, otherwise 4'b0000.
- step  output  4  update counter; 0 only before the first update.
- busy  output  1  high while the pipeline or emit is in flight (err_ready low).

Behaviour:
- Reset values: deltab2_* = 0, ctrl = 0, step = 0, err_ready = 0 for the reset cycle, busy = 0; accumulators, beat counter and sample counter = 0.
- err_ready goes high on the first cycle after rst deasserts.
- Handshake: a beat is accepted at an edge where err_valid && err_ready. Stalls on either side are legal. err_data and lr must be stable while err_valid=1.
- Neuron index comes from a 0..4 beat counter; there is no index port. The counter wraps 4->0 and increments the sample counter.
- Pipeline stage 1, at the acceptance edge E0: prod = err_data * lr, a 32-bit signed product.
- Pipeline stage 2, at edge E1: term = -(prod >>> FRAC), arithmetic shift (floor), sign-extended/saturated to ACC_W.
- Pipeline stage 3, at edge E2: acc[idx] = sat_ACC_W(acc[idx] + term).
- No wrap-around anywhere: all saturation clamps to the min/max signed value.
- Back-to-back beats are accepted at full rate (one per cycle).
- FSM states: ACC, DRAIN, EMIT.
  - ACC: err_ready=1. Accepting beat 5 of sample BATCH moves to DRAIN and drops err_ready at that same edge.
  - DRAIN: 2 cycles until the last term has landed in acc.
  - EMIT, at edge E3 after the final acceptance E0:
    - deltab2_k <= sat16(acc[k-1]); ctrl <= 4'b0001.
    - step <= (step==15) ? 1 : step+1; step is never 0 after the first update.
    - All acc, beat and sample counters are cleared.
  - At edge E4: ctrl <= 0, return to ACC, err_ready <= 1.
- The consumer therefore samples ctrl=0001 together with the new step and the new deltas at E4.
- deltab2_* hold their values until the next EMIT. Beats arriving during DRAIN/EMIT are not accepted.
- rst at any point, including mid-batch or in DRAIN/EMIT, discards partial accumulations and in-flight pipeline data and restores all reset values. A ctrl pulse that was due is suppressed.
- lr may change between beats; each beat uses the lr sampled with it.

Test Plan:
- Single sample: BATCH=1, FRAC=8, lr=0x0080, errors 0x0100, 0x0200, 0xFF00, 0x0000, 0x0080 sent back-to-back.
  -> deltab2_1..5 = 0xFF80, 0xFF00, 0x0080, 0x0000, 0xFFC0.
  -> ctrl=0001 and step=1 for exactly one cycle, 4 edges after the last acceptance.
- Batch accumulation: BATCH=3, lr=0x0100, err=0x0010 on all beats of all samples.
  -> one ctrl pulse only, after beat 15; all deltas 0xFFD0.
- Saturation: BATCH=4, lr=0x7FFF, every err=0x8000.
  -> acc clamps at 0x7FFFFF; all deltas 0x7FFF, no sign flip.
  -> repeat with err=0x7FFF, giving deltas 0x8000 to 0x8001 range clamped at 0x8000.
- Stall/backpressure: random err_valid gaps; err_valid held high during DRAIN/EMIT.
  -> no beats accepted while err_ready=0; results identical to the gap-free run.
- Step wrap: 16 consecutive updates with BATCH=1.
  -> step sequence 1..15, 1; step is never 0; ctrl pulse width is always 1 cycle.
- Reset mid-operation: rst for 1 cycle after 7 beats, then a fresh sample as in scenario 1.
  -> outputs return to 0 and step=0; the next update matches scenario 1 exactly with step=1.
  -> rst during DRAIN produces no ctrl pulse.

Source files
------------

// File: rtl/deltab2_gen.sv
// Output-layer bias delta generator: serial per-neuron errors are scaled by -lr,
// accumulated over BATCH samples, then emitted as saturated deltas with a one-cycle strobe.
module deltab2_gen #(
  parameter int unsigned BATCH = 1,
  parameter int unsigned FRAC  = 8,
  parameter int unsigned ACC_W = 24
) (
  input  logic               clk,
  input  logic               rst,
  input  logic signed [15:0] lr,
  input  logic               err_valid,
  output logic               err_ready,
  input  logic signed [15:0] err_data,
  output logic signed [15:0] deltab2_1,
  output logic signed [15:0] deltab2_2,
  output logic signed [15:0] deltab2_3,
  output logic signed [15:0] deltab2_4,
  output logic signed [15:0] deltab2_5,
  output logic [3:0]         ctrl,
  output logic [3:0]         step,
  output logic               busy
);

  typedef enum logic [1:0] {StAcc, StDrain, StEmit} state_e;

  state_e     state_q, state_d;
  logic       drain_q, drain_d;
  logic       ctrl_q, ctrl_d;
  logic       err_ready_q, err_ready_d;
  logic       emit;
  logic [2:0] beat_q;
  logic [7:0] sample_q;
  logic [3:0] step_q;
  logic       accept, last_beat;

  logic                    v1_q, v2_q;
  logic [2:0]              idx1_q, idx2_q;
  logic signed [31:0]      prod_q;
  logic signed [63:0]      prod_ext;
  logic signed [ACC_W-1:0] term_q, term_d, sum_d;
  logic signed [ACC_W-1:0] acc_q [5];
  logic signed [15:0]      delta_q [5];

  function automatic logic signed [ACC_W-1:0] sat_acc(input logic signed [63:0] v);
    logic signed [63:0] hi, lo;
    hi = (64'sd1 <<< (ACC_W - 1)) - 64'sd1;
    lo = -hi - 64'sd1;
    if (v > hi) begin
      sat_acc = hi[ACC_W-1:0];
    end else if (v < lo) begin
      sat_acc = lo[ACC_W-1:0];
    end else begin
      sat_acc = v[ACC_W-1:0];
    end
  endfunction

  function automatic logic signed [15:0] sat16(input logic signed [ACC_W-1:0] v);
    if (64'(v) > 64'sd32767) begin
      sat16 = 16'sh7fff;
    end else if (64'(v) < -64'sd32768) begin
      sat16 = 16'sh8000;
    end else begin
      sat16 = v[15:0];
    end
  endfunction

  assign accept    = err_valid && err_ready_q;
  assign last_beat = accept && (beat_q == 3'd4) && (sample_q == 8'(BATCH - 1));

  // Drain spans the two pipeline stages after the final acceptance; emit then takes two
  // cycles: first edge loads deltas and raises ctrl, second edge drops ctrl and reopens.
  always_comb begin
    state_d = state_q;
    drain_d = 1'b0;
    ctrl_d  = 1'b0;
    emit    = 1'b0;
    case (state_q)
      StAcc: begin
        if (last_beat) state_d = StDrain;
      end
      StDrain: begin
        drain_d = ~drain_q;
        if (drain_q) state_d = StEmit;
      end
      StEmit: begin
        if (!ctrl_q) begin
          emit   = 1'b1;
          ctrl_d = 1'b1;
        end else begin
          state_d = StAcc;
        end
      end
      default: state_d = StAcc;
    endcase
    err_ready_d = (state_d == StAcc);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StAcc;
      drain_q     <= 1'b0;
      ctrl_q      <= 1'b0;
      err_ready_q <= 1'b0;
      beat_q      <= 3'd0;
      sample_q    <= 8'd0;
      step_q      <= 4'd0;
    end else begin
      state_q     <= state_d;
      drain_q     <= drain_d;
      ctrl_q      <= ctrl_d;
      err_ready_q <= err_ready_d;
      if (emit) begin
        beat_q   <= 3'd0;
        sample_q <= 8'd0;
        step_q   <= (step_q == 4'd15) ? 4'd1 : step_q + 4'd1;
      end else if (accept) begin
        if (beat_q == 3'd4) begin
          beat_q   <= 3'd0;
          sample_q <= (sample_q == 8'(BATCH - 1)) ? 8'd0 : sample_q + 8'd1;
        end else begin
          beat_q <= beat_q + 3'd1;
        end
      end
    end
  end

  // Negation is done at 64 bits so the most negative product cannot wrap.
  always_comb begin
    prod_ext = 64'(prod_q);
    term_d   = sat_acc(-(prod_ext >>> FRAC));
    sum_d    = sat_acc(64'(acc_q[idx2_q]) + 64'(term_q));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      v1_q   <= 1'b0;
      v2_q   <= 1'b0;
      idx1_q <= 3'd0;
      idx2_q <= 3'd0;
      prod_q <= '0;
      term_q <= '0;
      for (int k = 0; k < 5; k++) begin
        acc_q[k]   <= '0;
        delta_q[k] <= '0;
      end
    end else begin
      v1_q <= accept;
      v2_q <= v1_q;
      if (accept) begin
        prod_q <= 32'(err_data) * 32'(lr);
        idx1_q <= beat_q;
      end
      if (v1_q) begin
        term_q <= term_d;
        idx2_q <= idx1_q;
      end
      if (emit) begin
        for (int k = 0; k < 5; k++) begin
          acc_q[k]   <= '0;
          delta_q[k] <= sat16(acc_q[k]);
        end
      end else if (v2_q) begin
        acc_q[idx2_q] <= sum_d;
      end
    end
  end

  assign err_ready = err_ready_q;
  assign busy      = (state_q != StAcc);
  assign ctrl      = {3'b000, ctrl_q};
  assign step      = step_q;
  assign deltab2_1 = delta_q[0];
  assign deltab2_2 = delta_q[1];
  assign deltab2_3 = delta_q[2];
  assign deltab2_4 = delta_q[3];
  assign deltab2_5 = delta_q[4];

endmodule

// File: tb/tb_deltab2_gen.sv
// Directed bench for deltab2_gen: three instances (BATCH 1, 3, 4) share clock, reset and data.
module tb_deltab2_gen;

  localparam logic [15:0] S1_ERR [5] = '{16'h0100, 16'h0200, 16'hFF00, 16'h0000, 16'h0080};
  localparam logic [15:0] S1_EXP [5] = '{16'hFF80, 16'hFF00, 16'h0080, 16'h0000, 16'hFFC0};

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] lr, err_data;
  logic        valid  [3];
  logic        rdy    [3];
  logic        busy_w [3];
  logic [3:0]  ctrl_w [3];
  logic [3:0]  step_w [3];
  logic [15:0] db     [3][5];
  int          pulses  [3] = '{0, 0, 0};
  int          accepts [3] = '{0, 0, 0};
  int          passed = 0;
  int          total  = 0;
  logic [15:0] exp_d [5];

  always #5 clk = ~clk;

  for (genvar g = 0; g < 3; g++) begin : g_dut
    deltab2_gen #(
      .BATCH(g == 0 ? 1 : (g == 1 ? 3 : 4)),
      .FRAC (8),
      .ACC_W(24)
    ) u_dut (
      .clk      (clk),
      .rst      (rst),
      .lr       (lr),
      .err_valid(valid[g]),
      .err_ready(rdy[g]),
      .err_data (err_data),
      .deltab2_1(db[g][0]),
      .deltab2_2(db[g][1]),
      .deltab2_3(db[g][2]),
      .deltab2_4(db[g][3]),
      .deltab2_5(db[g][4]),
      .ctrl     (ctrl_w[g]),
      .step     (step_w[g]),
      .busy     (busy_w[g])
    );
  end

  // Pre-edge values: counts strobe-high cycles and handshakes at each edge.
  always @(posedge clk) begin
    for (int g = 0; g < 3; g++) begin
      if (ctrl_w[g] != 4'd0) pulses[g]++;
      if (valid[g] && rdy[g]) accepts[g]++;
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, required $finish earlier");
    $fatal(1);
  end

  // Called on a falling edge; returns on the falling edge just after acceptance.
  task automatic send(input int g, input logic [15:0] d, input logic [15:0] l);
    int n;
    n = 0;
    valid[g] = 1'b1;
    err_data = d;
    lr       = l;
    while (!rdy[g] && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!rdy[g]) begin
      total++;
      $display("FAIL send_timeout inst%0d: err_ready=%b after %0d cycles, required 1", g, rdy[g], n);
    end
    @(negedge clk);
    valid[g] = 1'b0;
  endtask

  // Called on the falling edge right after the final acceptance edge E0.
  task automatic expect_update(input int g, input logic [3:0] es, input string nm);
    int p0;
    p0 = pulses[g];
    for (int i = 0; i < 3; i++) begin
      total++;
      if (ctrl_w[g] !== 4'd0 || rdy[g] !== 1'b0 || busy_w[g] !== 1'b1)
        $display("FAIL %s_drain%0d: ctrl=%b ready=%b busy=%b, required 0000/0/1",
                 nm, i, ctrl_w[g], rdy[g], busy_w[g]);
      else passed++;
      @(negedge clk);
    end
    valid[g] = 1'b0;
    total++;
    if (ctrl_w[g] !== 4'b0001 || step_w[g] !== es)
      $display("FAIL %s_strobe: ctrl=%b step=%0d, required 0001 step=%0d", nm, ctrl_w[g],
               step_w[g], es);
    else passed++;
    for (int k = 0; k < 5; k++) begin
      total++;
      if (db[g][k] !== exp_d[k])
        $display("FAIL %s_delta%0d: got %h, required %h", nm, k + 1, db[g][k], exp_d[k]);
      else passed++;
    end
    @(negedge clk);
    total++;
    if (ctrl_w[g] !== 4'd0 || rdy[g] !== 1'b1 || busy_w[g] !== 1'b0 || pulses[g] - p0 !== 1
        || db[g][0] !== exp_d[0] || db[g][4] !== exp_d[4])
      $display("FAIL %s_after: ctrl=%b ready=%b busy=%b pulse_cycles=%0d d1=%h d5=%h, required 0000/1/0/1/%h/%h",
               nm, ctrl_w[g], rdy[g], busy_w[g], pulses[g] - p0, db[g][0], db[g][4],
               exp_d[0], exp_d[4]);
    else passed++;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    lr = '0;
    err_data = '0;
    for (int g = 0; g < 3; g++) valid[g] = 1'b0;
    repeat (3) @(negedge clk);
    for (int g = 0; g < 3; g++) begin
      total++;
      if (rdy[g] !== 1'b0 || busy_w[g] !== 1'b0 || ctrl_w[g] !== 4'd0 || step_w[g] !== 4'd0 ||
          (db[g][0] | db[g][1] | db[g][2] | db[g][3] | db[g][4]) !== 16'd0)
        $display("FAIL reset_state inst%0d: ready=%b busy=%b ctrl=%b step=%0d, required all 0",
                 g, rdy[g], busy_w[g], ctrl_w[g], step_w[g]);
      else passed++;
    end
    rst = 1'b0;
    @(negedge clk);
    for (int g = 0; g < 3; g++) begin
      total++;
      if (rdy[g] !== 1'b1 || busy_w[g] !== 1'b0)
        $display("FAIL reset_release inst%0d: ready=%b busy=%b, required 1/0", g, rdy[g],
                 busy_w[g]);
      else passed++;
    end
  endtask

  task automatic test_single();
    for (int k = 0; k < 5; k++) exp_d[k] = S1_EXP[k];
    for (int k = 0; k < 5; k++) send(0, S1_ERR[k], 16'h0080);
    expect_update(0, 4'd1, "single");
  endtask

  task automatic test_lr_per_beat();
    exp_d = '{16'hFFF0, 16'hFFE0, 16'hFFD0, 16'hFFC0, 16'hFFB0};
    for (int k = 0; k < 5; k++) send(0, 16'h0100, 16'(16 * (k + 1)));
    expect_update(0, 4'd2, "lr_per_beat");
  endtask

  task automatic test_rounding();
    exp_d = '{16'h0001, 16'h0000, 16'h0002, 16'hFFFF, 16'h8000};
    send(0, 16'hFFFF, 16'h0001);
    send(0, 16'h0001, 16'h0001);
    send(0, 16'hFF80, 16'h0003);
    send(0, 16'h0180, 16'h0001);
    send(0, 16'h8000, 16'h8000);
    expect_update(0, 4'd3, "rounding");
  endtask

  task automatic test_batch();
    int p0;
    p0 = pulses[1];
    for (int i = 0; i < 10; i++) send(1, 16'h0010, 16'h0100);
    repeat (5) @(negedge clk);
    total++;
    if (pulses[1] != p0 || rdy[1] !== 1'b1)
      $display("FAIL batch_no_early: strobe cycles=%0d ready=%b, required 0/1", pulses[1] - p0,
               rdy[1]);
    else passed++;
    for (int k = 0; k < 5; k++) exp_d[k] = 16'hFFD0;
    for (int i = 0; i < 5; i++) send(1, 16'h0010, 16'h0100);
    expect_update(1, 4'd1, "batch");
  endtask

  task automatic test_saturation();
    for (int k = 0; k < 5; k++) exp_d[k] = 16'h7FFF;
    for (int i = 0; i < 20; i++) send(2, 16'h8000, 16'h7FFF);
    expect_update(2, 4'd1, "sat_pos");
    for (int k = 0; k < 5; k++) exp_d[k] = 16'h8000;
    for (int i = 0; i < 20; i++) send(2, 16'h7FFF, 16'h7FFF);
    expect_update(2, 4'd2, "sat_neg");
  endtask

  task automatic test_stall();
    int a0, n;
    a0 = accepts[0];
    for (int k = 0; k < 5; k++) exp_d[k] = S1_EXP[k];
    for (int k = 0; k < 4; k++) begin
      repeat ($urandom_range(0, 3)) @(negedge clk);
      send(0, S1_ERR[k], 16'h0080);
    end
    repeat ($urandom_range(1, 3)) @(negedge clk);
    valid[0] = 1'b1;
    err_data = S1_ERR[4];
    lr = 16'h0080;
    n = 0;
    while (!rdy[0] && n < 50) begin
      @(negedge clk);
      n++;
    end
    @(negedge clk);
    // Keep offering junk while the block is draining and emitting.
    err_data = 16'h7FFF;
    lr = 16'h7FFF;
    expect_update(0, 4'd4, "stall");
    total++;
    if (accepts[0] - a0 !== 5)
      $display("FAIL stall_accepts: got %0d beats, required 5", accepts[0] - a0);
    else passed++;
  endtask

  task automatic test_reset_mid();
    for (int i = 0; i < 7; i++) send(1, 16'h0100, 16'h0100);
    rst = 1'b1;
    @(negedge clk);
    for (int g = 0; g < 3; g++) begin
      total++;
      if (step_w[g] !== 4'd0 || ctrl_w[g] !== 4'd0 || rdy[g] !== 1'b0 ||
          (db[g][0] | db[g][1] | db[g][2] | db[g][3] | db[g][4]) !== 16'd0)
        $display("FAIL mid_reset inst%0d: step=%0d ctrl=%b ready=%b d1=%h, required 0/0000/0/0000",
                 g, step_w[g], ctrl_w[g], rdy[g], db[g][0]);
      else passed++;
    end
    rst = 1'b0;
    for (int k = 0; k < 5; k++) exp_d[k] = S1_EXP[k];
    for (int k = 0; k < 5; k++) send(0, S1_ERR[k], 16'h0080);
    expect_update(0, 4'd1, "mid_single");
    exp_d = '{16'hFE80, 16'hFD00, 16'h0180, 16'h0000, 16'hFF40};
    for (int s = 0; s < 3; s++)
      for (int k = 0; k < 5; k++) send(1, S1_ERR[k], 16'h0080);
    expect_update(1, 4'd1, "mid_batch");
  endtask

  task automatic test_reset_drain();
    int p0;
    for (int d = 0; d < 3; d++) begin
      p0 = pulses[0];
      for (int k = 0; k < 5; k++) send(0, S1_ERR[k], 16'h0080);
      repeat (d) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      repeat (6) @(negedge clk);
      total++;
      if (pulses[0] != p0 || step_w[0] !== 4'd0 || db[0][0] !== 16'd0 || rdy[0] !== 1'b1)
        $display("FAIL drain_reset%0d: strobe cycles=%0d step=%0d d1=%h ready=%b, required 0/0/0000/1",
                 d, pulses[0] - p0, step_w[0], db[0][0], rdy[0]);
      else passed++;
    end
  endtask

  task automatic test_step_wrap();
    for (int u = 1; u <= 16; u++) begin
      exp_d = '{16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0000};
      exp_d[0] = 16'(0 - u * 16);
      send(0, 16'h0100, 16'(u * 16));
      for (int k = 1; k < 5; k++) send(0, 16'h0000, 16'(u * 16));
      expect_update(0, (u <= 15) ? 4'(u) : 4'd1, $sformatf("wrap%0d", u));
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_lr_per_beat();
    test_rounding();
    test_batch();
    test_saturation();
    test_stall();
    test_reset_mid();
    test_reset_drain();
    test_step_wrap();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
